branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Consumer side of the EXU comparator. Accepts one branch or jump per handshake from ID/EXU and drives the comparator's control code and operands.
- Samples the comparator's 64-bit result and decides taken/not-taken. Computes the real next PC.
- On a mispredict, holds a redirect request to the IFU until it is accepted, then returns the link value to WBU.
- Sits in EXU beside the ALU and owns the branch and mispredict performance counters.

Parameters:
- XLEN, 64, datapath and PC width.
- CNT_W, 32, width of the performance counters (wrap on overflow).

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  branch request valid
- in_ready  out  1  high only in IDLE
- in_op  in  3  0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU, 6 JAL, 7 JALR
- in_pc, in_imm, in_rs1, in_rs2  in  XLEN  instruction PC, sign-extended immediate, operands
- in_pred_taken  in  1  IFU prediction taken
- in_pred_target  in  XLEN  IFU predicted target
- cmp_src1, cmp_src2  out  XLEN  comparator operands
- cmp_ctrl  out  4  comparator control code
- cmp_result  in  XLEN  comparator result; only bit 0 is used
- redir_valid  out  1  redirect request
- redir_ready  in  1  IFU accepts the redirect
- redir_pc  out  XLEN  correct next PC
- out_valid  out  1  result valid to WBU
- out_ready  in  1  WBU accepts the result
- out_link  out  XLEN  in_pc+4 (written to rd for JAL/JALR)
- out_taken  out  1  resolved direction
- out_misalign  out  1  taken target with bit 1 set
- br_cnt, mis_cnt  out  CNT_W  resolved-branch and mispredict counters

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE. All outputs 0 except in_ready=1, cmp_ctrl=4'hF. Both counters cleared. Any in-flight branch is discarded, including one in REDIR.
- States: IDLE, CMP, REDIR, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid=1: latch all in_* fields and go to CMP.
- CMP (one cycle):
  - cmp_src1 and cmp_src2 = latched rs1 and rs2.
  - cmp_ctrl by op: BEQ→1, BNE→0, BLT→3, BGE→2, BLTU→4, BGEU→4, JAL/JALR→4'hF.
  - taken = cmp_result[0], inverted for BGEU; forced to 1 for JAL/JALR.
  - Outside CMP, cmp_src1/cmp_src2=0 and cmp_ctrl=4'hF.
- Target:
  - JALR: (rs1+imm) & ~1.
  - All others: pc+imm.
  - All sums are modulo 2^XLEN.
  - next_pc = taken ? target : pc+4.
- Misalign:
  - misalign = taken & target[1].
  - When set: no redirect, go straight to DONE with out_misalign=1. The trap path handles it.
- Mispredict:
  - mis = (pred_taken != taken) | (taken & pred_target != target).
  - On mis without misalign: go to REDIR, else DONE.
  - br_cnt increments in every CMP cycle; mis_cnt increments when mis & !misalign.
- REDIR:
  - redir_valid=1 and redir_pc=next_pc, held stable until redir_ready.
  - On the handshake cycle go to DONE.
  - redir_ready while not in REDIR is ignored.
- DONE:
  - out_valid=1; out_link, out_taken, out_misalign held stable until out_ready.
  - On the handshake go to IDLE.
  - New input is not accepted in the same cycle; throughput is one branch per 3 cycles minimum.
- Latency: accept at edge 0; decision at edge 1.
  - out_valid first at cycle 2 when there is no redirect.
  - With a redirect: redir_valid at cycle 2, out_valid the cycle after redir_ready.
- Counters wrap from 2^CNT_W−1 to 0.

Decomposition:
- Shared package (ysyx EXU package):
  - branch op encoding constants BR_*.
  - comparator control codes MUX_NEQ_U=0, MUX_EQ_U=1, MUX_GE_S=2, MUX_LT_S=3, MUX_LT_U=4, MUX_NONE=4'hF.
  - state encoding constants.
- One natural sub-module: br_target_calc, combinational. It produces target, next_pc, link and misalign from pc, imm, rs1, op and taken.
- Instantiate the existing comparator beside this unit in the EXU top, not inside it.

Test Plan:
- BEQ, rs1=rs2=5, pred_taken=0, pc=0x80000000, imm=0x10 → cmp_ctrl=1 in CMP; redir_pc=0x80000010 at cycle 2; mis_cnt=1; out_link=0x80000004.
- BGEU, rs1=1, rs2=0xFFFF_FFFF_FFFF_FFFF, pred_taken=0 → cmp_ctrl=4, result 1 inverted gives taken=0; no redirect; out_valid at cycle 2; br_cnt=1, mis_cnt=0.
- JALR, rs1=0x80001003, imm=0, pred_taken=1, pred_target=0x80001002 → target 0x80001002; target[1]=1 so out_misalign=1, no redirect.
- BLT with a correct taken prediction whose pred_target differs by 4 → redirect to the real target; hold redir_ready=0 for 3 cycles, redir_valid/redir_pc stay stable; out_valid the cycle after acceptance.
- Assert rst_n=0 while in REDIR → redir_valid drops asynchronously, in_ready=1, counters 0; the next branch resolves normally.
- Back-to-back in_valid with out_ready held low 4 cycles → in_ready=0 throughout DONE; the second request is accepted only after the out handshake.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared EXU branch definitions: op encodings, comparator control codes, FSM states.
package branch_resolve_unit_pkg;

  localparam logic [2:0] BR_BEQ  = 3'd0;
  localparam logic [2:0] BR_BNE  = 3'd1;
  localparam logic [2:0] BR_BLT  = 3'd2;
  localparam logic [2:0] BR_BGE  = 3'd3;
  localparam logic [2:0] BR_BLTU = 3'd4;
  localparam logic [2:0] BR_BGEU = 3'd5;
  localparam logic [2:0] BR_JAL  = 3'd6;
  localparam logic [2:0] BR_JALR = 3'd7;

  localparam logic [3:0] MUX_NEQ_U = 4'd0;
  localparam logic [3:0] MUX_EQ_U  = 4'd1;
  localparam logic [3:0] MUX_GE_S  = 4'd2;
  localparam logic [3:0] MUX_LT_S  = 4'd3;
  localparam logic [3:0] MUX_LT_U  = 4'd4;
  localparam logic [3:0] MUX_NONE  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMP   = 2'd1,
    ST_REDIR = 2'd2,
    ST_DONE  = 2'd3
  } br_state_e;

  // BGEU reuses the unsigned less-than code; the unit inverts the result.
  function automatic logic [3:0] br_cmp_ctrl(input logic [2:0] op);
    logic [3:0] ctrl;
    ctrl = MUX_NONE;
    case (op)
      BR_BEQ:           ctrl = MUX_EQ_U;
      BR_BNE:           ctrl = MUX_NEQ_U;
      BR_BLT:           ctrl = MUX_LT_S;
      BR_BGE:           ctrl = MUX_GE_S;
      BR_BLTU, BR_BGEU: ctrl = MUX_LT_U;
      default:          ctrl = MUX_NONE;
    endcase
    return ctrl;
  endfunction

  function automatic logic br_is_jump(input logic [2:0] op);
    return (op == BR_JAL) || (op == BR_JALR);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Handshake and datapath bundle between ID/EXU, the comparator, IFU redirect and WBU.
interface branch_resolve_unit_if #(
  parameter int unsigned XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic            in_pred_taken;
  logic [XLEN-1:0] in_pred_target;

  logic [XLEN-1:0] cmp_src1;
  logic [XLEN-1:0] cmp_src2;
  logic [3:0]      cmp_ctrl;
  logic [XLEN-1:0] cmp_result;

  logic            redir_valid;
  logic            redir_ready;
  logic [XLEN-1:0] redir_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_link;
  logic            out_taken;
  logic            out_misalign;

  modport master (
    output in_valid, in_op, in_pc, in_imm, in_rs1, in_rs2, in_pred_taken, in_pred_target,
    output cmp_result, redir_ready, out_ready,
    input  in_ready, cmp_src1, cmp_src2, cmp_ctrl, redir_valid, redir_pc,
    input  out_valid, out_link, out_taken, out_misalign
  );

  modport slave (
    input  in_valid, in_op, in_pc, in_imm, in_rs1, in_rs2, in_pred_taken, in_pred_target,
    input  cmp_result, redir_ready, out_ready,
    output in_ready, cmp_src1, cmp_src2, cmp_ctrl, redir_valid, redir_pc,
    output out_valid, out_link, out_taken, out_misalign
  );
endinterface

// File: rtl/branch_resolve_unit_br_target_calc.sv
// Combinational target / next-PC / link / misalignment computation for a resolved branch.
module br_target_calc
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic [2:0]      op,
  input  logic            taken,
  output logic [XLEN-1:0] target,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] link,
  output logic            misalign
);
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] pc_sum;

  always_comb begin
    jalr_sum = rs1 + imm;
    pc_sum   = pc + imm;
    target   = (op == BR_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : pc_sum;
    link     = pc + XLEN'(4);
    next_pc  = taken ? target : link;
    misalign = taken & target[1];
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution FSM: drives the external comparator, decides direction and redirect, reports to WBU.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_resolve_unit_if.slave  io,
  output logic [CNT_W-1:0]      br_cnt,
  output logic [CNT_W-1:0]      mis_cnt
);
  br_state_e       state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic            pred_taken_q, pred_taken_d;
  logic [XLEN-1:0] pred_target_q, pred_target_d;

  logic            in_ready_q, in_ready_d;
  logic [XLEN-1:0] cmp_src1_q, cmp_src1_d;
  logic [XLEN-1:0] cmp_src2_q, cmp_src2_d;
  logic [3:0]      cmp_ctrl_q, cmp_ctrl_d;
  logic            redir_valid_q, redir_valid_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_link_q, out_link_d;
  logic            out_taken_q, out_taken_d;
  logic            out_misalign_q, out_misalign_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

  logic            taken;
  logic            mis;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] link;
  logic            misalign;
  logic            unused_cmp_hi;

  assign unused_cmp_hi = ^io.cmp_result[XLEN-1:1];

  always_comb begin
    if (br_is_jump(op_q))      taken = 1'b1;
    else if (op_q == BR_BGEU)  taken = ~io.cmp_result[0];
    else                       taken = io.cmp_result[0];
  end

  br_target_calc #(.XLEN(XLEN)) u_target (
    .pc       (pc_q),
    .imm      (imm_q),
    .rs1      (rs1_q),
    .op       (op_q),
    .taken    (taken),
    .target   (target),
    .next_pc  (next_pc),
    .link     (link),
    .misalign (misalign)
  );

  assign mis = (pred_taken_q != taken) | (taken & (pred_target_q != target));

  // Comparator operands/control are registered on accept so they are valid throughout CMP.
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    pc_d           = pc_q;
    imm_d          = imm_q;
    rs1_d          = rs1_q;
    pred_taken_d   = pred_taken_q;
    pred_target_d  = pred_target_q;
    in_ready_d     = in_ready_q;
    cmp_src1_d     = cmp_src1_q;
    cmp_src2_d     = cmp_src2_q;
    cmp_ctrl_d     = cmp_ctrl_q;
    redir_valid_d  = redir_valid_q;
    redir_pc_d     = redir_pc_q;
    out_valid_d    = out_valid_q;
    out_link_d     = out_link_q;
    out_taken_d    = out_taken_q;
    out_misalign_d = out_misalign_q;
    br_cnt_d       = br_cnt_q;
    mis_cnt_d      = mis_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (io.in_valid) begin
          op_d          = io.in_op;
          pc_d          = io.in_pc;
          imm_d         = io.in_imm;
          rs1_d         = io.in_rs1;
          pred_taken_d  = io.in_pred_taken;
          pred_target_d = io.in_pred_target;
          cmp_src1_d    = io.in_rs1;
          cmp_src2_d    = io.in_rs2;
          cmp_ctrl_d    = br_cmp_ctrl(io.in_op);
          in_ready_d    = 1'b0;
          state_d       = ST_CMP;
        end
      end
      ST_CMP: begin
        cmp_src1_d     = '0;
        cmp_src2_d     = '0;
        cmp_ctrl_d     = MUX_NONE;
        br_cnt_d       = br_cnt_q + CNT_W'(1);
        out_link_d     = link;
        out_taken_d    = taken;
        out_misalign_d = misalign;
        if (mis && !misalign) begin
          mis_cnt_d     = mis_cnt_q + CNT_W'(1);
          redir_valid_d = 1'b1;
          redir_pc_d    = next_pc;
          state_d       = ST_REDIR;
        end else begin
          out_valid_d   = 1'b1;
          state_d       = ST_DONE;
        end
      end
      ST_REDIR: begin
        if (io.redir_ready) begin
          redir_valid_d = 1'b0;
          out_valid_d   = 1'b1;
          state_d       = ST_DONE;
        end
      end
      ST_DONE: begin
        if (io.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      op_q           <= '0;
      pc_q           <= '0;
      imm_q          <= '0;
      rs1_q          <= '0;
      pred_taken_q   <= 1'b0;
      pred_target_q  <= '0;
      in_ready_q     <= 1'b1;
      cmp_src1_q     <= '0;
      cmp_src2_q     <= '0;
      cmp_ctrl_q     <= MUX_NONE;
      redir_valid_q  <= 1'b0;
      redir_pc_q     <= '0;
      out_valid_q    <= 1'b0;
      out_link_q     <= '0;
      out_taken_q    <= 1'b0;
      out_misalign_q <= 1'b0;
      br_cnt_q       <= '0;
      mis_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      pc_q           <= pc_d;
      imm_q          <= imm_d;
      rs1_q          <= rs1_d;
      pred_taken_q   <= pred_taken_d;
      pred_target_q  <= pred_target_d;
      in_ready_q     <= in_ready_d;
      cmp_src1_q     <= cmp_src1_d;
      cmp_src2_q     <= cmp_src2_d;
      cmp_ctrl_q     <= cmp_ctrl_d;
      redir_valid_q  <= redir_valid_d;
      redir_pc_q     <= redir_pc_d;
      out_valid_q    <= out_valid_d;
      out_link_q     <= out_link_d;
      out_taken_q    <= out_taken_d;
      out_misalign_q <= out_misalign_d;
      br_cnt_q       <= br_cnt_d;
      mis_cnt_q      <= mis_cnt_d;
    end
  end

  assign io.in_ready     = in_ready_q;
  assign io.cmp_src1     = cmp_src1_q;
  assign io.cmp_src2     = cmp_src2_q;
  assign io.cmp_ctrl     = cmp_ctrl_q;
  assign io.redir_valid  = redir_valid_q;
  assign io.redir_pc     = redir_pc_q;
  assign io.out_valid    = out_valid_q;
  assign io.out_link     = out_link_q;
  assign io.out_taken    = out_taken_q;
  assign io.out_misalign = out_misalign_q;
  assign br_cnt          = br_cnt_q;
  assign mis_cnt         = mis_cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed branches, a comparator model, queued expectations.
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CNT_W-1:0] br_cnt, mis_cnt;

  branch_resolve_unit_if #(.XLEN(XLEN)) bus ();

  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .io      (bus),
    .br_cnt  (br_cnt),
    .mis_cnt (mis_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model of the EXU comparator that sits beside the unit.
  logic cmp_bit;
  always_comb begin
    cmp_bit = 1'b0;
    case (bus.cmp_ctrl)
      4'd0: cmp_bit = (bus.cmp_src1 != bus.cmp_src2);
      4'd1: cmp_bit = (bus.cmp_src1 == bus.cmp_src2);
      4'd2: cmp_bit = ($signed(bus.cmp_src1) >= $signed(bus.cmp_src2));
      4'd3: cmp_bit = ($signed(bus.cmp_src1) <  $signed(bus.cmp_src2));
      4'd4: cmp_bit = (bus.cmp_src1 < bus.cmp_src2);
      default: cmp_bit = 1'b0;
    endcase
  end
  assign bus.cmp_result = {{(XLEN-1){1'b0}}, cmp_bit};

  typedef struct { logic [3:0] ctrl; logic [63:0] s1; logic [63:0] s2; } cmp_exp_t;
  typedef struct { logic [63:0] link; logic taken; logic mis; } out_exp_t;

  cmp_exp_t    cmp_q[$];
  logic [63:0] redir_q[$];
  out_exp_t    out_q[$];

  int total = 0;
  int bad   = 0;
  int n_out = 0;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Monitor: pops expectations whenever the DUT presents a comparator cycle or a handshake.
  initial begin : monitor
    bit          cmp_pend;
    bit          stalled;
    logic [63:0] last_rpc;
    cmp_exp_t    ce;
    out_exp_t    oe;
    logic [63:0] rp;
    cmp_pend = 0;
    stalled  = 0;
    last_rpc = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cmp_pend = 0;
        stalled  = 0;
        continue;
      end
      if (cmp_pend) begin
        check("cmp_q_nonempty", cmp_q.size(), (cmp_q.size() > 0) ? cmp_q.size() : 1);
        if (cmp_q.size() > 0) begin
          ce = cmp_q.pop_front();
          check("cmp_ctrl", bus.cmp_ctrl, ce.ctrl);
          check("cmp_src1", bus.cmp_src1, ce.s1);
          check("cmp_src2", bus.cmp_src2, ce.s2);
        end
        cmp_pend = 0;
      end else begin
        check("cmp_ctrl_idle", bus.cmp_ctrl, MUX_NONE);
        check("cmp_src1_idle", bus.cmp_src1, 64'd0);
      end
      if (stalled) begin
        check("redir_valid_hold", bus.redir_valid, 1'b1);
        check("redir_pc_hold", bus.redir_pc, last_rpc);
      end
      stalled  = bus.redir_valid && !bus.redir_ready;
      last_rpc = bus.redir_pc;
      if (bus.redir_valid && bus.redir_ready) begin
        if (redir_q.size() == 0) check("redir_unexpected", bus.redir_valid, 1'b0);
        else begin
          rp = redir_q.pop_front();
          check("redir_pc", bus.redir_pc, rp);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (out_q.size() == 0) check("out_unexpected", bus.out_valid, 1'b0);
        else begin
          oe = out_q.pop_front();
          check("out_link", bus.out_link, oe.link);
          check("out_taken", bus.out_taken, oe.taken);
          check("out_misalign", bus.out_misalign, oe.mis);
        end
      end
      if (bus.in_valid && bus.in_ready) cmp_pend = 1;
    end
  end

  task automatic issue(input logic [2:0] op, input logic [63:0] pc, input logic [63:0] imm,
                       input logic [63:0] rs1, input logic [63:0] rs2,
                       input logic pt, input logic [63:0] ptgt, input logic [3:0] e_ctrl,
                       input bit has_redir, input logic [63:0] e_rpc,
                       input bit has_out, input logic [63:0] e_link, input logic e_taken,
                       input logic e_mis);
    cmp_exp_t ce;
    out_exp_t oe;
    bit acc;
    ce.ctrl = e_ctrl; ce.s1 = rs1; ce.s2 = rs2;
    cmp_q.push_back(ce);
    if (has_redir) redir_q.push_back(e_rpc);
    if (has_out) begin
      oe.link = e_link; oe.taken = e_taken; oe.mis = e_mis;
      out_q.push_back(oe);
    end
    bus.in_op = op; bus.in_pc = pc; bus.in_imm = imm; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
    bus.in_pred_taken = pt; bus.in_pred_target = ptgt;
    bus.in_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 40 && !acc; i++) begin
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    check("accept_in_time", acc, 1'b1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int i;
    i = 0;
    while (n_out < n && i < 50) begin
      @(posedge clk);
      i++;
    end
    #1;
    check("out_count", n_out, n);
  endtask

  task automatic check_cnt(input logic [CNT_W-1:0] eb, input logic [CNT_W-1:0] em);
    check("br_cnt", br_cnt, eb);
    check("mis_cnt", mis_cnt, em);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bus.in_valid = 0; bus.in_op = '0; bus.in_pc = '0; bus.in_imm = '0;
    bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_pred_taken = 0; bus.in_pred_target = '0;
    bus.redir_ready = 1; bus.out_ready = 1;
    #12;
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_cmp_ctrl", bus.cmp_ctrl, 4'hF);
    check("rst_redir_valid", bus.redir_valid, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check_cnt(0, 0);
    rst_n = 1;
    @(posedge clk); #1;

    // BEQ taken, predicted not-taken: redirect at cycle 2
    issue(BR_BEQ, 64'h8000_0000, 64'h10, 64'd5, 64'd5, 0, 64'h0, 4'd1,
          1, 64'h8000_0010, 1, 64'h8000_0004, 1, 0);
    @(posedge clk); #1;
    check("beq_redir_c2", bus.redir_valid, 1'b1);
    wait_out(1);
    check_cnt(1, 1);

    // BGEU with comparator result 1 inverted: not taken, no redirect
    issue(BR_BGEU, 64'h8000_0100, 64'h20, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h0, 4'd4,
          0, 64'h0, 1, 64'h8000_0104, 0, 0);
    @(posedge clk); #1;
    check("bgeu_out_c2", bus.out_valid, 1'b1);
    check("bgeu_no_redir", bus.redir_valid, 1'b0);
    wait_out(2);
    check_cnt(2, 1);

    // JALR landing on a halfword: misaligned, no redirect
    issue(BR_JALR, 64'h8000_0200, 64'h0, 64'h8000_1003, 64'h0, 1, 64'h8000_1002, 4'hF,
          0, 64'h0, 1, 64'h8000_0204, 1, 1);
    @(posedge clk); #1;
    check("jalr_out_c2", bus.out_valid, 1'b1);
    check("jalr_no_redir", bus.redir_valid, 1'b0);
    wait_out(3);

    // BLT taken with wrong predicted target; IFU stalls 3 cycles
    bus.redir_ready = 0;
    issue(BR_BLT, 64'h8000_0300, 64'h40, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 1, 64'h8000_0344, 4'd3,
          1, 64'h8000_0340, 1, 64'h8000_0304, 1, 0);
    @(posedge clk); #1;
    check("blt_redir_c2", bus.redir_valid, 1'b1);
    check("blt_no_out", bus.out_valid, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      check("blt_stall_pc", bus.redir_pc, 64'h8000_0340);
      check("blt_stall_out", bus.out_valid, 1'b0);
    end
    bus.redir_ready = 1;
    @(posedge clk); #1;
    check("blt_out_after_acc", bus.out_valid, 1'b1);
    check("blt_redir_drop", bus.redir_valid, 1'b0);
    wait_out(4);
    check_cnt(4, 2);

    issue(BR_BNE, 64'h8000_0400, 64'h8, 64'd7, 64'd7, 0, 64'h0, 4'd0,
          0, 64'h0, 1, 64'h8000_0404, 0, 0);
    wait_out(5);
    issue(BR_BLTU, 64'h8000_0500, 64'hFFFF_FFFF_FFFF_FFF8, 64'd2, 64'd3, 1, 64'h8000_04F8, 4'd4,
          0, 64'h0, 1, 64'h8000_0504, 1, 0);
    wait_out(6);
    issue(BR_JAL, 64'h8000_0600, 64'h100, 64'h0, 64'h0, 0, 64'h0, 4'hF,
          1, 64'h8000_0700, 1, 64'h8000_0604, 1, 0);
    wait_out(7);
    issue(BR_BGE, 64'h8000_0800, 64'h20, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 64'h8000_0820, 4'd2,
          1, 64'h8000_0804, 1, 64'h8000_0804, 0, 0);
    wait_out(8);
    check_cnt(8, 4);

    // Reset while a redirect is pending discards the branch
    bus.redir_ready = 0;
    issue(BR_BEQ, 64'h8000_0900, 64'h8, 64'd1, 64'd1, 0, 64'h0, 4'd1,
          0, 64'h0, 0, 64'h0, 0, 0);
    @(posedge clk); #1;
    check("rst_test_redir_pre", bus.redir_valid, 1'b1);
    #2;
    rst_n = 0;
    #1;
    check("async_redir_drop", bus.redir_valid, 1'b0);
    check("async_in_ready", bus.in_ready, 1'b1);
    check("async_cmp_ctrl", bus.cmp_ctrl, 4'hF);
    check_cnt(0, 0);
    @(negedge clk); #2;
    rst_n = 1;
    bus.redir_ready = 1;
    @(posedge clk); #1;
    issue(BR_BNE, 64'h8000_0A00, 64'h20, 64'd1, 64'd2, 1, 64'h8000_0A20, 4'd0,
          0, 64'h0, 1, 64'h8000_0A04, 1, 0);
    wait_out(9);
    check_cnt(1, 0);

    // Back-to-back requests while WBU holds out_ready low
    bus.out_ready = 0;
    issue(BR_BEQ, 64'h8000_0B00, 64'h10, 64'd3, 64'd4, 0, 64'h0, 4'd1,
          0, 64'h0, 1, 64'h8000_0B04, 0, 0);
    fork
      issue(BR_BLTU, 64'h8000_0C00, 64'h10, 64'd5, 64'd3, 0, 64'h0, 4'd4,
            0, 64'h0, 1, 64'h8000_0C04, 0, 0);
      begin
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
          check("b2b_in_ready_low", bus.in_ready, 1'b0);
          check("b2b_out_valid_hold", bus.out_valid, 1'b1);
          check("b2b_out_count", n_out, 9);
          @(posedge clk); #1;
        end
        bus.out_ready = 1;
      end
    join
    wait_out(11);
    check_cnt(3, 0);

    check("cmp_q_drained", cmp_q.size(), 0);
    check("redir_q_drained", redir_q.size(), 0);
    check("out_q_drained", out_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
